regfile_port_arbiter: RTL and testbench

Shares the 32x32 register file (single write port, dual read port, reads and writes sampled on the clock edge) between two requesters, e.g. the ALU writeback client (client 0) and the load/debug client (client 1).
- Round-robin request/grant handshake per client.
- Registers the winning command onto the register file pins.
- Routes the file's o1/o2 read data back to the owning client with a valid strobe.
- Sits between the datapath clients and the register file.

---
 rtl/rf_arb_pkg.sv | 23 ++
 rtl/rf_rr_arb2.sv | 34 +++
 rtl/regfile_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_regfile_port_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// The issue-stage command struct is sized by RF_DATA_W/RF_ADDR_W; the top
// parameters are expected to match these defaults.
package rf_arb_pkg;

   localparam int unsigned RF_DATA_W = 32;
   localparam int unsigned RF_ADDR_W = 5;

   localparam logic CLIENT0 = 1'b0;
   localparam logic CLIENT1 = 1'b1;

   // Command captured from the winning client for the issue stage
   typedef struct packed {
      logic                 rd;
      logic                 we;
      logic                 owner;
      logic [RF_ADDR_W-1:0] raddr1;
      logic [RF_ADDR_W-1:0] raddr2;
      logic [RF_ADDR_W-1:0] waddr;
      logic [RF_DATA_W-1:0] wdata;
   } rf_cmd_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-way round-robin arbiter; last points at the most recently granted client.
module rf_rr_arb2
   import rf_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last;

   // Lone requester wins; on contention the client that did not win last time wins
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req == 2'b11) begin
            gnt = (last == CLIENT1) ? 2'b01 : 2'b10;
         end else begin
            gnt = req;
         end
      end
   end

   // Remember the granted client; reset favours client 0 next
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last <= CLIENT1;
      end else if (gnt != 2'b00) begin
         last <= gnt[1];
      end
   end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares one 1W/2R register file between two clients: arbitrate (N),
// issue registered command to the file (N+1), return read data (N+2).
// Optional build macro RF_ARB_ZERO_REG_EN hard-wires register 0 to zero.
module regfile_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned DATA_W = RF_DATA_W,
   parameter int unsigned ADDR_W = RF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c0_req,
   input  logic              c0_rd,
   input  logic              c0_we,
   input  logic [ADDR_W-1:0] c0_raddr1,
   input  logic [ADDR_W-1:0] c0_raddr2,
   input  logic [ADDR_W-1:0] c0_waddr,
   input  logic [DATA_W-1:0] c0_wdata,
   output logic              c0_gnt,
   output logic              c0_rvalid,
   output logic [DATA_W-1:0] c0_rdata1,
   output logic [DATA_W-1:0] c0_rdata2,
   input  logic              c1_req,
   input  logic              c1_rd,
   input  logic              c1_we,
   input  logic [ADDR_W-1:0] c1_raddr1,
   input  logic [ADDR_W-1:0] c1_raddr2,
   input  logic [ADDR_W-1:0] c1_waddr,
   input  logic [DATA_W-1:0] c1_wdata,
   output logic              c1_gnt,
   output logic              c1_rvalid,
   output logic [DATA_W-1:0] c1_rdata1,
   output logic [DATA_W-1:0] c1_rdata2,
   output logic              rf_read,
   output logic              rf_write,
   output logic [ADDR_W-1:0] rf_o1_addr,
   output logic [ADDR_W-1:0] rf_o2_addr,
   output logic [ADDR_W-1:0] rf_in_addr,
   output logic [DATA_W-1:0] rf_in,
   input  logic [DATA_W-1:0] rf_o1,
   input  logic [DATA_W-1:0] rf_o2
);

   logic [1:0]        req;
   logic [1:0]        gnt;
   rf_cmd_t           win;
   logic              win_we;
   logic              iss_rd;
   logic              iss_owner;
   logic [1:0]        rsp_valid;
   logic [DATA_W-1:0] rd1;
   logic [DATA_W-1:0] rd2;
   logic [DATA_W-1:0] c0_hold1;
   logic [DATA_W-1:0] c0_hold2;
   logic [DATA_W-1:0] c1_hold1;
   logic [DATA_W-1:0] c1_hold2;
`ifdef RF_ARB_ZERO_REG_EN
   logic              rsp_zero1;
   logic              rsp_zero2;
`endif

   assign req = {c1_req, c0_req};

   rf_rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (req),
      .gnt (gnt)
   );

   assign c0_gnt = gnt[0];
   assign c1_gnt = gnt[1];

   // Select the granted client's command fields
   always_comb begin
      win = '0;
      if (gnt[1]) begin
         win.rd     = c1_rd;
         win.we     = c1_we;
         win.owner  = CLIENT1;
         win.raddr1 = RF_ADDR_W'(c1_raddr1);
         win.raddr2 = RF_ADDR_W'(c1_raddr2);
         win.waddr  = RF_ADDR_W'(c1_waddr);
         win.wdata  = RF_DATA_W'(c1_wdata);
      end else if (gnt[0]) begin
         win.rd     = c0_rd;
         win.we     = c0_we;
         win.owner  = CLIENT0;
         win.raddr1 = RF_ADDR_W'(c0_raddr1);
         win.raddr2 = RF_ADDR_W'(c0_raddr2);
         win.waddr  = RF_ADDR_W'(c0_waddr);
         win.wdata  = RF_DATA_W'(c0_wdata);
      end
`ifdef RF_ARB_ZERO_REG_EN
      win_we = win.we && (win.waddr != '0);
`else
      win_we = win.we;
`endif
   end

   // Issue stage: drive the file pins; addresses/data hold when nothing is granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_read    <= 1'b0;
         rf_write   <= 1'b0;
         rf_o1_addr <= '0;
         rf_o2_addr <= '0;
         rf_in_addr <= '0;
         rf_in      <= '0;
         iss_rd     <= 1'b0;
         iss_owner  <= CLIENT0;
      end else begin
         rf_read  <= 1'b0;
         rf_write <= 1'b0;
         iss_rd   <= 1'b0;
         if (gnt != 2'b00) begin
            rf_read    <= win.rd;
            rf_write   <= win_we;
            rf_o1_addr <= ADDR_W'(win.raddr1);
            rf_o2_addr <= ADDR_W'(win.raddr2);
            rf_in_addr <= ADDR_W'(win.waddr);
            rf_in      <= DATA_W'(win.wdata);
            iss_rd     <= win.rd;
            iss_owner  <= win.owner;
         end
      end
   end

   // Response stage: flag which client gets the data the file presents next cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 2'b00;
`ifdef RF_ARB_ZERO_REG_EN
         rsp_zero1 <= 1'b0;
         rsp_zero2 <= 1'b0;
`endif
      end else begin
         rsp_valid[0] <= iss_rd && (iss_owner == CLIENT0);
         rsp_valid[1] <= iss_rd && (iss_owner == CLIENT1);
`ifdef RF_ARB_ZERO_REG_EN
         rsp_zero1 <= (rf_o1_addr == '0);
         rsp_zero2 <= (rf_o2_addr == '0);
`endif
      end
   end

   // Read data from the file, with register 0 masked when hard-wired
   always_comb begin
      rd1 = rf_o1;
      rd2 = rf_o2;
`ifdef RF_ARB_ZERO_REG_EN
      if (rsp_zero1) rd1 = '0;
      if (rsp_zero2) rd2 = '0;
`endif
   end

   // Keep each client's last delivered data so it holds outside its own rvalid
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c0_hold1 <= '0;
         c0_hold2 <= '0;
         c1_hold1 <= '0;
         c1_hold2 <= '0;
      end else begin
         if (rsp_valid[0]) begin
            c0_hold1 <= rd1;
            c0_hold2 <= rd2;
         end
         if (rsp_valid[1]) begin
            c1_hold1 <= rd1;
            c1_hold2 <= rd2;
         end
      end
   end

   assign c0_rvalid = rsp_valid[0];
   assign c1_rvalid = rsp_valid[1];
   assign c0_rdata1 = rsp_valid[0] ? rd1 : c0_hold1;
   assign c0_rdata2 = rsp_valid[0] ? rd2 : c0_hold2;
   assign c1_rdata1 = rsp_valid[1] ? rd1 : c1_hold1;
   assign c1_rdata2 = rsp_valid[1] ? rd2 : c1_hold2;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Cycle-by-cycle directed vectors for regfile_port_arbiter against a simple
// synchronous register-file model (reads sampled before writes on the edge).
module tb_regfile_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        c0_req, c0_rd, c0_we, c1_req, c1_rd, c1_we;
   logic [4:0]  c0_raddr1, c0_raddr2, c0_waddr, c1_raddr1, c1_raddr2, c1_waddr;
   logic [31:0] c0_wdata, c1_wdata;
   logic        c0_gnt, c0_rvalid, c1_gnt, c1_rvalid;
   logic [31:0] c0_rdata1, c0_rdata2, c1_rdata1, c1_rdata2;
   logic        rf_read, rf_write;
   logic [4:0]  rf_o1_addr, rf_o2_addr, rf_in_addr;
   logic [31:0] rf_in;
   logic [31:0] rf_o1 = '0;
   logic [31:0] rf_o2 = '0;

   always #5 clk = ~clk;

   regfile_port_arbiter dut (
      .clk(clk), .rst(rst),
      .c0_req(c0_req), .c0_rd(c0_rd), .c0_we(c0_we),
      .c0_raddr1(c0_raddr1), .c0_raddr2(c0_raddr2), .c0_waddr(c0_waddr), .c0_wdata(c0_wdata),
      .c0_gnt(c0_gnt), .c0_rvalid(c0_rvalid), .c0_rdata1(c0_rdata1), .c0_rdata2(c0_rdata2),
      .c1_req(c1_req), .c1_rd(c1_rd), .c1_we(c1_we),
      .c1_raddr1(c1_raddr1), .c1_raddr2(c1_raddr2), .c1_waddr(c1_waddr), .c1_wdata(c1_wdata),
      .c1_gnt(c1_gnt), .c1_rvalid(c1_rvalid), .c1_rdata1(c1_rdata1), .c1_rdata2(c1_rdata2),
      .rf_read(rf_read), .rf_write(rf_write),
      .rf_o1_addr(rf_o1_addr), .rf_o2_addr(rf_o2_addr), .rf_in_addr(rf_in_addr),
      .rf_in(rf_in), .rf_o1(rf_o1), .rf_o2(rf_o2)
   );

   // Register file model: unwritten registers read as 1000+index
   logic [31:0] mem [32];
   logic [31:0] wmask = '0;

   function automatic logic [31:0] rf_val(input logic [4:0] a);
      return wmask[a] ? mem[a] : 32'd1000 + 32'(a);
   endfunction

   always @(posedge clk) begin
      if (rf_read) begin
         rf_o1 <= rf_val(rf_o1_addr);
         rf_o2 <= rf_val(rf_o2_addr);
      end
      if (rf_write) begin
         mem[rf_in_addr]   <= rf_in;
         wmask[rf_in_addr] <= 1'b1;
      end
   end

   typedef struct {
      logic        req, rd, we;
      logic [4:0]  ra1, ra2, wa;
      logic [31:0] wd;
   } cmd_t;

   typedef struct {
      logic [1:0]  g;
      logic        r, w;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [1:0]  v;
      logic [31:0] d1, d2;
   } exp_t;

   typedef struct {
      cmd_t c0;
      cmd_t c1;
      exp_t e;
   } row_t;

   row_t        tbl[$];
   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] h01 = '0, h02 = '0, h11 = '0, h12 = '0;

   function automatic cmd_t mk(input logic rd, input logic we, input int a1, input int a2,
                               input int wa, input int wd);
      cmd_t c;
      c.req = 1'b1; c.rd = rd; c.we = we;
      c.ra1 = 5'(a1); c.ra2 = 5'(a2); c.wa = 5'(wa); c.wd = 32'(wd);
      return c;
   endfunction

   function automatic cmd_t nil();
      cmd_t c;
      c.req = 1'b0; c.rd = 1'b0; c.we = 1'b0;
      c.ra1 = '0; c.ra2 = '0; c.wa = '0; c.wd = '0;
      return c;
   endfunction

   function automatic cmd_t wr(input int a, input int d);
      return mk(1'b0, 1'b1, 0, 0, a, d);
   endfunction

   function automatic cmd_t rdc(input int a1, input int a2);
      return mk(1'b1, 1'b0, a1, a2, 0, 0);
   endfunction

   function automatic exp_t ex(input int g, input int r, input int w, input int wa, input int wd,
                               input int v, input int d1, input int d2);
      exp_t e;
      e.g = 2'(g); e.r = 1'(r); e.w = 1'(w); e.wa = 5'(wa); e.wd = 32'(wd);
      e.v = 2'(v); e.d1 = 32'(d1); e.d2 = 32'(d2);
      return e;
   endfunction

   function automatic row_t R(input cmd_t a, input cmd_t b, input exp_t e);
      row_t t;
      t.c0 = a; t.c1 = b; t.e = e;
      return t;
   endfunction

   task automatic chk(input string tag, input string what, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s %s: got %0d, expected %0d", tag, what, act, exp);
      end
   endtask

   task automatic drive(input cmd_t a, input cmd_t b);
      c0_req = a.req; c0_rd = a.rd; c0_we = a.we;
      c0_raddr1 = a.ra1; c0_raddr2 = a.ra2; c0_waddr = a.wa; c0_wdata = a.wd;
      c1_req = b.req; c1_rd = b.rd; c1_we = b.we;
      c1_raddr1 = b.ra1; c1_raddr2 = b.ra2; c1_waddr = b.wa; c1_wdata = b.wd;
   endtask

   task automatic check_rdata(input string tag);
      chk(tag, "c0_rdata1", c0_rdata1, h01);
      chk(tag, "c0_rdata2", c0_rdata2, h02);
      chk(tag, "c1_rdata1", c1_rdata1, h11);
      chk(tag, "c1_rdata2", c1_rdata2, h12);
   endtask

   // One clock of stimulus, outputs checked mid-way through the low phase
   task automatic apply(input row_t t, input string tag);
      @(negedge clk);
      drive(t.c0, t.c1);
      #1;
      chk(tag, "gnt", 32'({c1_gnt, c0_gnt}), 32'(t.e.g));
      chk(tag, "rf_read", 32'(rf_read), 32'(t.e.r));
      chk(tag, "rf_write", 32'(rf_write), 32'(t.e.w));
      if (t.e.w) begin
         chk(tag, "rf_in_addr", 32'(rf_in_addr), 32'(t.e.wa));
         chk(tag, "rf_in", rf_in, t.e.wd);
      end
      chk(tag, "rvalid", 32'({c1_rvalid, c0_rvalid}), 32'(t.e.v));
      if (t.e.v[0]) begin h01 = t.e.d1; h02 = t.e.d2; end
      if (t.e.v[1]) begin h11 = t.e.d1; h12 = t.e.d2; end
      check_rdata(tag);
   endtask

   initial begin
      // write r30 and r10, read them back
      tbl.push_back(R(wr(30, 111111),   nil(),        ex(1, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(wr(10, 9999999),  nil(),        ex(1, 0, 1, 30, 111111, 0, 0, 0)));
      tbl.push_back(R(rdc(30, 10),      nil(),        ex(1, 0, 1, 10, 9999999, 0, 0, 0)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 1, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 0, 0, 0, 0, 1, 111111, 9999999)));
      // c1 alone, then both contend for four cycles
      tbl.push_back(R(nil(),            wr(7, 777),   ex(2, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(rdc(30, 10),      rdc(10, 7),   ex(1, 0, 1, 7, 777, 0, 0, 0)));
      tbl.push_back(R(rdc(7, 30),       rdc(10, 7),   ex(2, 1, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(rdc(7, 30),       rdc(30, 30),  ex(1, 1, 0, 0, 0, 1, 111111, 9999999)));
      tbl.push_back(R(rdc(10, 10),      rdc(30, 30),  ex(2, 1, 0, 0, 0, 2, 9999999, 777)));
      tbl.push_back(R(rdc(10, 10),      nil(),        ex(1, 1, 0, 0, 0, 1, 777, 111111)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 1, 0, 0, 0, 2, 111111, 111111)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 0, 0, 0, 0, 1, 9999999, 9999999)));
      // read-before-write in one command, then later read sees new value
      tbl.push_back(R(nil(),            wr(5, 7),     ex(2, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(mk(1'b1, 1'b1, 5, 5, 5, 42), nil(), ex(1, 0, 1, 5, 7, 0, 0, 0)));
      tbl.push_back(R(rdc(5, 5),        nil(),        ex(1, 1, 1, 5, 42, 0, 0, 0)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 1, 0, 0, 0, 1, 7, 7)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 0, 0, 0, 0, 1, 42, 42)));
      // request with neither rd nor we: granted, no enables, no rvalid
      tbl.push_back(R(nil(),            mk(1'b0, 1'b0, 1, 2, 3, 4), ex(2, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 0, 0, 0, 0, 0, 0, 0)));
      tbl.push_back(R(nil(),            nil(),        ex(0, 0, 0, 0, 0, 0, 0, 0)));

      // reset state, with a request held to show gnt stays low
      drive(mk(1'b1, 1'b1, 1, 2, 3, 4), nil());
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset", "gnt", 32'({c1_gnt, c0_gnt}), 32'd0);
      chk("reset", "rf_read", 32'(rf_read), 32'd0);
      chk("reset", "rf_write", 32'(rf_write), 32'd0);
      chk("reset", "rf_addrs", 32'({rf_o1_addr, rf_o2_addr, rf_in_addr}), 32'd0);
      chk("reset", "rf_in", rf_in, 32'd0);
      chk("reset", "rvalid", 32'({c1_rvalid, c0_rvalid}), 32'd0);
      check_rdata("reset");
      drive(nil(), nil());
      rst = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], $sformatf("row%0d", i));
      end

      // asynchronous reset during the issue cycle of a write to r3
      apply(R(wr(3, 55), nil(), ex(1, 0, 0, 0, 0, 0, 0, 0)), "rst_gnt");
      @(negedge clk);
      drive(nil(), nil());
      #1;
      chk("rst_issue", "rf_write", 32'(rf_write), 32'd1);
      chk("rst_issue", "rf_in_addr", 32'(rf_in_addr), 32'd3);
      rst = 1'b1;
      #1;
      h01 = '0; h02 = '0; h11 = '0; h12 = '0;
      chk("rst_async", "rf_write", 32'(rf_write), 32'd0);
      chk("rst_async", "rf_read", 32'(rf_read), 32'd0);
      chk("rst_async", "rvalid", 32'({c1_rvalid, c0_rvalid}), 32'd0);
      check_rdata("rst_async");
      @(negedge clk);
      #1;
      chk("rst_hold", "rf_write", 32'(rf_write), 32'd0);
      rst = 1'b0;
      apply(R(nil(), nil(), ex(0, 0, 0, 0, 0, 0, 0, 0)), "post_rst0");
      apply(R(nil(), nil(), ex(0, 0, 0, 0, 0, 0, 0, 0)), "post_rst1");
      apply(R(rdc(3, 3), nil(), ex(1, 0, 0, 0, 0, 0, 0, 0)), "r3_gnt");
      apply(R(nil(), nil(), ex(0, 1, 0, 0, 0, 0, 0, 0)), "r3_issue");
      apply(R(nil(), nil(), ex(0, 0, 0, 0, 0, 1, 1003, 1003)), "r3_data");

`ifdef RF_ARB_ZERO_REG_EN
      // register 0 is hard-wired: write suppressed, reads return zero
      apply(R(wr(0, 123), nil(), ex(1, 0, 0, 0, 0, 0, 0, 0)), "z_wgnt");
      apply(R(rdc(0, 3), nil(), ex(1, 0, 0, 0, 0, 0, 0, 0)), "z_rgnt");
      apply(R(nil(), nil(), ex(0, 1, 0, 0, 0, 0, 0, 0)), "z_issue");
      apply(R(nil(), nil(), ex(0, 0, 0, 0, 0, 1, 0, 1003)), "z_data");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
